// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between the I-cache and D-cache miss engines.
// Requests are latched per port, granted round-robin, and issued one at a time.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_we,
    input  logic              i_start,
    output logic [DATA_W-1:0] i_q,
    output logic              i_done,
    output logic              i_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_we,
    input  logic              d_start,
    output logic [DATA_W-1:0] d_q,
    output logic              d_done,
    output logic              d_ready,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [DATA_W-1:0] sd_data,
    output logic              sd_we,
    output logic              sd_start,
    input  logic [DATA_W-1:0] sd_q,
    input  logic              sd_done,
    input  logic              sd_ready
);

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_pend_i;
    logic              r_pend_d;
    logic [ADDR_W-1:0] r_addr_i;
    logic [ADDR_W-1:0] r_addr_d;
    logic [DATA_W-1:0] r_data_i;
    logic [DATA_W-1:0] r_data_d;
    logic              r_we_i;
    logic              r_we_d;
    logic              r_last;
    logic              r_gnt;
    logic              w_any;
    logic              w_win;
    logic              w_issue;
    logic              w_complete;

    // On a tie the port that was not granted last time wins.
    assign w_any   = r_pend_i | r_pend_d;
    assign w_win   = (r_pend_i & r_pend_d) ? ~r_last : r_pend_d;
    assign i_ready = ~r_pend_i;
    assign d_ready = ~r_pend_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any && sd_ready) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (sd_done) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Holding registers: a start is taken only while the port has nothing pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_i <= 1'b0;
            r_pend_d <= 1'b0;
            r_addr_i <= '0;
            r_addr_d <= '0;
            r_data_i <= '0;
            r_data_d <= '0;
            r_we_i   <= 1'b0;
            r_we_d   <= 1'b0;
        end else begin
            if (i_start && !r_pend_i) begin
                r_pend_i <= 1'b1;
                r_addr_i <= i_addr;
                r_data_i <= i_data;
                r_we_i   <= i_we;
            end else if (w_complete && (r_gnt == PORT_I)) begin
                r_pend_i <= 1'b0;
            end
            if (d_start && !r_pend_d) begin
                r_pend_d <= 1'b1;
                r_addr_d <= d_addr;
                r_data_d <= d_data;
                r_we_d   <= d_we;
            end else if (w_complete && (r_gnt == PORT_D)) begin
                r_pend_d <= 1'b0;
            end
        end
    end

    // Downstream command; address/data/we hold between transactions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sd_start <= 1'b0;
            sd_addr  <= '0;
            sd_data  <= '0;
            sd_we    <= 1'b0;
            r_gnt    <= PORT_I;
            r_last   <= PORT_I;
        end else begin
            sd_start <= w_issue;
            if (w_issue) begin
                sd_addr <= (w_win == PORT_D) ? r_addr_d : r_addr_i;
                sd_data <= (w_win == PORT_D) ? r_data_d : r_data_i;
                sd_we   <= (w_win == PORT_D) ? r_we_d   : r_we_i;
                r_gnt   <= w_win;
                r_last  <= w_win;
            end
        end
    end

    // Completion routing back to the granted port only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            i_q    <= '0;
            d_q    <= '0;
        end else begin
            i_done <= w_complete && (r_gnt == PORT_I);
            d_done <= w_complete && (r_gnt == PORT_D);
            if (w_complete && (r_gnt == PORT_I)) begin
                i_q <= sd_q;
            end
            if (w_complete && (r_gnt == PORT_D)) begin
                d_q <= sd_q;
            end
        end
    end

endmodule
